axi_aw_route_decoder: RTL

- Per-slave-port write-address decoder and W-channel router for the AXI4 node.
- Decodes each AW address against N_INIT_PORT address regions and forwards AW to the selected initiator-side port.
- Routes the following W burst to the same port using an in-order routing FIFO.
- On decode miss: drains the W burst itself and raises an error request toward the write-response allocator, which returns DECERR. Sits directly upstream of that allocator and feeds its incr_req, full_counter, sample and error handshakes.

---
 rtl/axi_node_pkg.sv | 27 ++
 rtl/axi_aw_route_decoder_if.sv | 38 +++
 rtl/axi_route_fifo.sv | 55 +++++
 rtl/axi_aw_route_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes, W-route FIFO entry and W FSM encoding.
package axi_node_pkg;

  localparam int unsigned DEF_N_INIT_PORT = 8;
  localparam int unsigned DEF_AXI_ADDR_W  = 32;
  localparam int unsigned DEF_AXI_ID_IN   = 16;
  localparam int unsigned DEF_AXI_USER_W  = 6;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;

  localparam int unsigned SEL_W = $clog2(DEF_N_INIT_PORT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One entry per accepted AW: where its W burst goes, or that it must be drained.
  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] sel;
  } route_entry_t;

  typedef enum logic [1:0] {
    W_ROUTE = 2'd0,
    W_DRAIN = 2'd1,
    ERR_REQ = 2'd2
  } w_state_e;

endpackage

// File: rtl/axi_aw_route_decoder_if.sv
// Slave-side AW/W channels and their one-hot initiator-side fan-out.
interface axi_aw_route_decoder_if
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = DEF_N_INIT_PORT,
  parameter int unsigned AXI_ADDR_W  = DEF_AXI_ADDR_W,
  parameter int unsigned AXI_ID_IN   = DEF_AXI_ID_IN,
  parameter int unsigned AXI_USER_W  = DEF_AXI_USER_W
);

  logic                   awvalid_i;
  logic [AXI_ADDR_W-1:0]  awaddr_i;
  logic [AXI_ID_IN-1:0]   awid_i;
  logic [AXI_USER_W-1:0]  awuser_i;
  logic                   awready_o;
  logic [N_INIT_PORT-1:0] awvalid_o;
  logic [N_INIT_PORT-1:0] awready_i;
  logic                   wvalid_i;
  logic                   wlast_i;
  logic                   wready_o;
  logic [N_INIT_PORT-1:0] wvalid_o;
  logic [N_INIT_PORT-1:0] wready_i;

  // Decoder side.
  modport slave (
    input  awvalid_i, awaddr_i, awid_i, awuser_i, awready_i,
    input  wvalid_i, wlast_i, wready_i,
    output awready_o, awvalid_o, wready_o, wvalid_o
  );

  // Environment side: upstream master plus downstream initiator ports.
  modport master (
    output awvalid_i, awaddr_i, awid_i, awuser_i, awready_i,
    output wvalid_i, wlast_i, wready_i,
    input  awready_o, awvalid_o, wready_o, wvalid_o
  );

endinterface

// File: rtl/axi_route_fifo.sv
// In-order synchronous FIFO holding W routing decisions; full is judged before any same-cycle pop.
module axi_route_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push_en;
  logic              pop_en;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Storage write; contents are don't-care while the entry is not live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_aw_route_decoder.sv
// AW address decoder and W-burst router; decode misses are drained locally and reported as DECERR requests.
module axi_aw_route_decoder
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = DEF_N_INIT_PORT,
  parameter int unsigned AXI_ADDR_W  = DEF_AXI_ADDR_W,
  parameter int unsigned AXI_ID_IN   = DEF_AXI_ID_IN,
  parameter int unsigned AXI_USER_W  = DEF_AXI_USER_W,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  axi_aw_route_decoder_if.slave                 bus,
  input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] start_addr_i,
  input  logic [N_INIT_PORT-1:0][AXI_ADDR_W-1:0] end_addr_i,
  input  logic [N_INIT_PORT-1:0]                enable_region_i,
  output logic                                  incr_req_o,
  input  logic                                  full_counter_i,
  output logic                                  sample_awdata_info_o,
  output logic                                  error_req_o,
  input  logic                                  error_gnt_i,
  output logic [AXI_ID_IN-1:0]                  error_id_o,
  output logic [AXI_USER_W-1:0]                 error_user_o
);

  localparam int unsigned ENTRY_W  = $bits(route_entry_t);
  localparam logic [1:0]  ST_ROUTE = 2'(W_ROUTE);
  localparam logic [1:0]  ST_DRAIN = 2'(W_DRAIN);
  localparam logic [1:0]  ST_ERR   = 2'(ERR_REQ);

  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic                  aw_gate;
  logic                  aw_accept;
  route_entry_t          push_entry;
  route_entry_t          head;
  logic [ENTRY_W-1:0]    head_raw;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  w_pop;
  logic [1:0]            state_q, state_d;
  logic                  err_pending_q;
  logic [AXI_ID_IN-1:0]  err_id_q;
  logic [AXI_USER_W-1:0] err_user_q;

  // Region decode: first enabled region containing the address, lowest index first.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < N_INIT_PORT; i++) begin
      if (!dec_hit && enable_region_i[i] &&
          (bus.awaddr_i >= start_addr_i[i]) && (bus.awaddr_i <= end_addr_i[i])) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  // AW forwarding: valid is never gated by ready; a miss is absorbed here once no error is pending.
  assign aw_gate    = bus.awvalid_i && !fifo_full && !full_counter_i;
  assign aw_accept  = aw_gate && (dec_hit ? bus.awready_i[dec_sel] : !err_pending_q);
  assign bus.awready_o = aw_accept;
  assign incr_req_o    = aw_accept;
  assign push_entry    = '{err: !dec_hit, sel: dec_sel};

  // One-hot AW valid toward the decoded initiator port.
  always_comb begin
    bus.awvalid_o = '0;
    if (dec_hit && aw_gate) begin
      bus.awvalid_o[dec_sel] = 1'b1;
    end
  end

  axi_route_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_route_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (aw_accept),
    .data_i  (push_entry),
    .pop_i   (w_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  assign head = route_entry_t'(head_raw);

  // Capture ID/user of the errored burst and track the single outstanding decode error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pending_q <= 1'b0;
      err_id_q      <= '0;
      err_user_q    <= '0;
    end else if (aw_accept && !dec_hit) begin
      err_pending_q <= 1'b1;
      err_id_q      <= bus.awid_i;
      err_user_q    <= bus.awuser_i;
    end else if ((state_q == ST_ERR) && error_gnt_i) begin
      err_pending_q <= 1'b0;
    end
  end

  assign error_id_o   = err_id_q;
  assign error_user_o = err_user_q;

  // W FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ROUTE;
    else        state_q <= state_d;
  end

  // W FSM: route head-of-FIFO burst, or drain it and request a DECERR response.
  always_comb begin
    state_d              = state_q;
    w_pop                = 1'b0;
    bus.wready_o         = 1'b0;
    bus.wvalid_o         = '0;
    error_req_o          = 1'b0;
    sample_awdata_info_o = 1'b0;
    case (state_q)
      ST_ROUTE: begin
        if (!fifo_empty) begin
          if (head.err) begin
            state_d = ST_DRAIN;
          end else begin
            bus.wvalid_o[head.sel] = bus.wvalid_i;
            bus.wready_o           = bus.wready_i[head.sel];
            w_pop = bus.wvalid_i && bus.wready_i[head.sel] && bus.wlast_i;
          end
        end
      end
      ST_DRAIN: begin
        bus.wready_o = 1'b1;
        if (bus.wvalid_i && bus.wlast_i) state_d = ST_ERR;
      end
      ST_ERR: begin
        error_req_o          = 1'b1;
        sample_awdata_info_o = 1'b1;
        if (error_gnt_i) begin
          w_pop   = 1'b1;
          state_d = ST_ROUTE;
        end
      end
      default: state_d = ST_ROUTE;
    endcase
  end

endmodule
